// File: rtl/dual_issue_scoreboard.sv
// dual_issue_scoreboard: in-order pair hold buffer, per-register latency
// scoreboard and even/odd dispatch with branch flush and perf counters.
module dual_issue_scoreboard #(
  parameter int unsigned NUM_REGS = 128,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned MAX_LAT  = 7,
  parameter int unsigned LAT_W    = $clog2(MAX_LAT + 1),
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                s0_valid,
  input  logic [INSTR_W-1:0]  s0_instr,
  input  logic                s0_pipe,
  input  logic                s0_wr,
  input  logic [ADDR_W-1:0]   s0_rt,
  input  logic [3*ADDR_W-1:0] s0_src,
  input  logic [2:0]          s0_src_en,
  input  logic [LAT_W-1:0]    s0_lat,
  input  logic                s1_valid,
  input  logic [INSTR_W-1:0]  s1_instr,
  input  logic                s1_pipe,
  input  logic                s1_wr,
  input  logic [ADDR_W-1:0]   s1_rt,
  input  logic [3*ADDR_W-1:0] s1_src,
  input  logic [2:0]          s1_src_en,
  input  logic [LAT_W-1:0]    s1_lat,
  input  logic                flush,
  output logic                even_valid,
  output logic                odd_valid,
  output logic [INSTR_W-1:0]  even_instr,
  output logic [INSTR_W-1:0]  odd_instr,
  output logic [CNT_W-1:0]    dual_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int unsigned SRC_W = 3 * ADDR_W;

  // Hold buffer, one entry per slot (index 0 is the older instruction)
  logic [1:0]         pend_q, pend_d;
  logic [INSTR_W-1:0] instr_q [2];
  logic [INSTR_W-1:0] instr_d [2];
  logic [1:0]         pipe_q, pipe_d, wr_q, wr_d;
  logic [ADDR_W-1:0]  rt_q [2];
  logic [ADDR_W-1:0]  rt_d [2];
  logic [SRC_W-1:0]   src_q [2];
  logic [SRC_W-1:0]   src_d [2];
  logic [2:0]         en_q [2];
  logic [2:0]         en_d [2];
  logic [LAT_W-1:0]   lat_q [2];
  logic [LAT_W-1:0]   lat_d [2];

  // Scoreboard countdowns
  logic [LAT_W-1:0]   cnt_q [NUM_REGS];
  logic [LAT_W-1:0]   cnt_d [NUM_REGS];

  logic               even_valid_q, even_valid_d, odd_valid_q, odd_valid_d;
  logic [INSTR_W-1:0] even_instr_q, even_instr_d, odd_instr_q, odd_instr_d;
  logic [CNT_W-1:0]   dual_cnt_q, dual_cnt_d, stall_cnt_q, stall_cnt_d;

  logic [1:0]         rdy;
  logic [LAT_W-1:0]   lat_eff [2];
  logic               pair_ok, iss0, iss1, accept;

  // Per-slot readiness against the scoreboard and effective writeback latency
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rdy[i] = 1'b1;
      for (int j = 0; j < 3; j++) begin
        if (en_q[i][j] && (cnt_q[src_q[i][j*ADDR_W +: ADDR_W]] != '0)) rdy[i] = 1'b0;
      end
      if (wr_q[i] && (cnt_q[rt_q[i]] != '0)) rdy[i] = 1'b0;
      if (lat_q[i] == '0)                    lat_eff[i] = LAT_W'(1);
      else if (32'(lat_q[i]) > MAX_LAT)      lat_eff[i] = LAT_W'(MAX_LAT);
      else                                   lat_eff[i] = lat_q[i];
    end
  end

  // Issue decision: in order, slot 1 pairs with slot 0 only when hazard-free
  always_comb begin
    pair_ok = (pipe_q[1] != pipe_q[0]);
    if (wr_q[0]) begin
      for (int j = 0; j < 3; j++) begin
        if (en_q[1][j] && (src_q[1][j*ADDR_W +: ADDR_W] == rt_q[0])) pair_ok = 1'b0;
      end
      if (wr_q[1] && (rt_q[1] == rt_q[0])) pair_ok = 1'b0;
    end
    iss0     = !flush && pend_q[0] && rdy[0];
    iss1     = !flush && pend_q[1] && rdy[1] && (!pend_q[0] || (iss0 && pair_ok));
    in_ready = !flush && (!pend_q[0] || iss0) && (!pend_q[1] || iss1);
    accept   = in_valid && in_ready;
  end

  // Hold buffer update: retire issued slots, load a new pair, or drop on flush
  always_comb begin
    pend_d  = pend_q & ~{iss1, iss0};
    instr_d = instr_q;
    pipe_d  = pipe_q;
    wr_d    = wr_q;
    rt_d    = rt_q;
    src_d   = src_q;
    en_d    = en_q;
    lat_d   = lat_q;
    if (flush) begin
      pend_d = '0;
    end else if (accept) begin
      pend_d     = {s1_valid, s0_valid};
      instr_d[0] = s0_instr;  instr_d[1] = s1_instr;
      pipe_d     = {s1_pipe, s0_pipe};
      wr_d       = {s1_wr, s0_wr};
      rt_d[0]    = s0_rt;     rt_d[1]    = s1_rt;
      src_d[0]   = s0_src;    src_d[1]   = s1_src;
      en_d[0]    = s0_src_en; en_d[1]    = s1_src_en;
      lat_d[0]   = s0_lat;    lat_d[1]   = s1_lat;
    end
  end

  // Scoreboard: decrement nonzero counters; an issuing writer reloads its rt
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - LAT_W'(1);
      if (iss0 && wr_q[0] && (rt_q[0] == ADDR_W'(r))) cnt_d[r] = lat_eff[0];
      if (iss1 && wr_q[1] && (rt_q[1] == ADDR_W'(r))) cnt_d[r] = lat_eff[1];
    end
  end

  // Pipe output registers and saturating performance counters
  always_comb begin
    even_valid_d = 1'b0;
    odd_valid_d  = 1'b0;
    even_instr_d = even_instr_q;
    odd_instr_d  = odd_instr_q;
    dual_cnt_d   = dual_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (iss0) begin
      if (pipe_q[0]) begin odd_valid_d  = 1'b1; odd_instr_d  = instr_q[0]; end
      else           begin even_valid_d = 1'b1; even_instr_d = instr_q[0]; end
    end
    if (iss1) begin
      if (pipe_q[1]) begin odd_valid_d  = 1'b1; odd_instr_d  = instr_q[1]; end
      else           begin even_valid_d = 1'b1; even_instr_d = instr_q[1]; end
    end
    if (iss0 && iss1 && !(&dual_cnt_q)) dual_cnt_d = dual_cnt_q + CNT_W'(1);
    if ((|pend_q) && !iss0 && !iss1 && !flush && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      pipe_q <= '0;
      wr_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        rt_q[i]    <= '0;
        src_q[i]   <= '0;
        en_q[i]    <= '0;
        lat_q[i]   <= '0;
      end
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      even_valid_q <= 1'b0;
      odd_valid_q  <= 1'b0;
      even_instr_q <= '0;
      odd_instr_q  <= '0;
      dual_cnt_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      pend_q       <= pend_d;
      pipe_q       <= pipe_d;
      wr_q         <= wr_d;
      instr_q      <= instr_d;
      rt_q         <= rt_d;
      src_q        <= src_d;
      en_q         <= en_d;
      lat_q        <= lat_d;
      cnt_q        <= cnt_d;
      even_valid_q <= even_valid_d;
      odd_valid_q  <= odd_valid_d;
      even_instr_q <= even_instr_d;
      odd_instr_q  <= odd_instr_d;
      dual_cnt_q   <= dual_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign even_valid = even_valid_q;
  assign odd_valid  = odd_valid_q;
  assign even_instr = even_instr_q;
  assign odd_instr  = odd_instr_q;
  assign dual_cnt   = dual_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Directed bench for dual_issue_scoreboard; a second instance with 3-bit
// perf counters shares the stimulus to exercise counter saturation.
module tb_dual_issue_scoreboard;

  logic        clk, reset, in_valid, flush;
  logic        s0_valid, s0_pipe, s0_wr, s1_valid, s1_pipe, s1_wr;
  logic [31:0] s0_instr, s1_instr;
  logic [6:0]  s0_rt, s1_rt;
  logic [20:0] s0_src, s1_src;
  logic [2:0]  s0_src_en, s1_src_en, s0_lat, s1_lat;

  logic        in_ready, even_valid, odd_valid;
  logic [31:0] even_instr, odd_instr, dual_cnt, stall_cnt;
  logic        sat_in_ready, sat_even_valid, sat_odd_valid;
  logic [31:0] sat_even_instr, sat_odd_instr;
  logic [2:0]  sat_dual_cnt, sat_stall_cnt;

  int checks = 0;
  int errors = 0;

  dual_issue_scoreboard dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .s0_valid(s0_valid), .s0_instr(s0_instr), .s0_pipe(s0_pipe), .s0_wr(s0_wr),
    .s0_rt(s0_rt), .s0_src(s0_src), .s0_src_en(s0_src_en), .s0_lat(s0_lat),
    .s1_valid(s1_valid), .s1_instr(s1_instr), .s1_pipe(s1_pipe), .s1_wr(s1_wr),
    .s1_rt(s1_rt), .s1_src(s1_src), .s1_src_en(s1_src_en), .s1_lat(s1_lat),
    .flush(flush), .even_valid(even_valid), .odd_valid(odd_valid),
    .even_instr(even_instr), .odd_instr(odd_instr),
    .dual_cnt(dual_cnt), .stall_cnt(stall_cnt)
  );

  dual_issue_scoreboard #(.CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready),
    .s0_valid(s0_valid), .s0_instr(s0_instr), .s0_pipe(s0_pipe), .s0_wr(s0_wr),
    .s0_rt(s0_rt), .s0_src(s0_src), .s0_src_en(s0_src_en), .s0_lat(s0_lat),
    .s1_valid(s1_valid), .s1_instr(s1_instr), .s1_pipe(s1_pipe), .s1_wr(s1_wr),
    .s1_rt(s1_rt), .s1_src(s1_src), .s1_src_en(s1_src_en), .s1_lat(s1_lat),
    .flush(flush), .even_valid(sat_even_valid), .odd_valid(sat_odd_valid),
    .even_instr(sat_even_instr), .odd_instr(sat_odd_instr),
    .dual_cnt(sat_dual_cnt), .stall_cnt(sat_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one slot; the single src register is replicated into ra/rb/rc
  task automatic set_slot(input int n, input logic v, input logic [31:0] ins,
                          input logic pipe, input logic wr, input logic [6:0] rt,
                          input logic [6:0] src, input logic [2:0] en,
                          input logic [2:0] lat);
    if (n == 0) begin
      s0_valid = v; s0_instr = ins; s0_pipe = pipe; s0_wr = wr; s0_rt = rt;
      s0_src = {src, src, src}; s0_src_en = en; s0_lat = lat;
    end else begin
      s1_valid = v; s1_instr = ins; s1_pipe = pipe; s1_wr = wr; s1_rt = rt;
      s1_src = {src, src, src}; s1_src_en = en; s1_lat = lat;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    set_slot(0, 1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 7'd0, 3'b000, 3'd0);
    set_slot(1, 1'b0, 32'h0, 1'b0, 1'b0, 7'd0, 7'd0, 3'b000, 3'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_even_valid", 64'(even_valid), 64'(0));
    check("rst_odd_valid",  64'(odd_valid),  64'(0));
    check("rst_even_instr", 64'(even_instr), 64'(0));
    check("rst_odd_instr",  64'(odd_instr),  64'(0));
    check("rst_dual_cnt",   64'(dual_cnt),   64'(0));
    check("rst_stall_cnt",  64'(stall_cnt),  64'(0));
    check("rst_in_ready",   64'(in_ready),   64'(1));

    // Independent pair A, then B back to back
    in_valid = 1'b1;
    set_slot(0, 1'b1, 32'hA0, 1'b0, 1'b1, 7'd3, 7'd0, 3'b000, 3'd2);
    set_slot(1, 1'b1, 32'hA1, 1'b1, 1'b1, 7'd4, 7'd0, 3'b000, 3'd6);
    #1 check("a_in_ready", 64'(in_ready), 64'(1));
    tick();
    set_slot(0, 1'b1, 32'hB0, 1'b0, 1'b1, 7'd10, 7'd0, 3'b000, 3'd1);
    set_slot(1, 1'b1, 32'hB1, 1'b1, 1'b1, 7'd11, 7'd0, 3'b000, 3'd1);
    #1 check("b2b_in_ready", 64'(in_ready), 64'(1));
    tick();
    idle();
    check("a_even_valid", 64'(even_valid), 64'(1));
    check("a_even_instr", 64'(even_instr), 64'h0A0);
    check("a_odd_valid",  64'(odd_valid),  64'(1));
    check("a_odd_instr",  64'(odd_instr),  64'h0A1);
    check("a_dual_cnt",   64'(dual_cnt),   64'(1));
    #1 check("b_in_ready", 64'(in_ready), 64'(1));
    tick();
    check("b_even_instr", 64'(even_instr), 64'h0B0);
    check("b_odd_instr",  64'(odd_instr),  64'h0B1);
    check("b_dual_cnt",   64'(dual_cnt),   64'(2));

    // Same-pipe pair C: serialised on the even pipe
    in_valid = 1'b1;
    set_slot(0, 1'b1, 32'hC0, 1'b0, 1'b0, 7'd0, 7'd0, 3'b000, 3'd1);
    set_slot(1, 1'b1, 32'hC1, 1'b0, 1'b0, 7'd0, 7'd0, 3'b000, 3'd1);
    #1 check("c_in_ready", 64'(in_ready), 64'(1));
    tick();
    idle();
    check("c_idle_even", 64'(even_valid), 64'(0));
    #1 check("c_in_ready_low", 64'(in_ready), 64'(0));
    tick();
    check("c0_even_valid", 64'(even_valid), 64'(1));
    check("c0_even_instr", 64'(even_instr), 64'h0C0);
    check("c0_odd_valid",  64'(odd_valid),  64'(0));
    #1 check("c1_in_ready", 64'(in_ready), 64'(1));
    tick();
    check("c1_even_valid", 64'(even_valid), 64'(1));
    check("c1_even_instr", 64'(even_instr), 64'h0C1);
    check("c1_odd_valid",  64'(odd_valid),  64'(0));
    check("c_dual_cnt",    64'(dual_cnt),   64'(2));
    check("c_stall_cnt",   64'(stall_cnt),  64'(0));

    // Intra-pair RAW on r5 with lat=2
    in_valid = 1'b1;
    set_slot(0, 1'b1, 32'hD0, 1'b0, 1'b1, 7'd5, 7'd0, 3'b000, 3'd2);
    set_slot(1, 1'b1, 32'hD1, 1'b1, 1'b0, 7'd0, 7'd5, 3'b111, 3'd1);
    tick();
    idle();
    #1 check("d_in_ready_low", 64'(in_ready), 64'(0));
    tick();
    check("d0_even_instr", 64'(even_instr), 64'h0D0);
    check("d0_odd_valid",  64'(odd_valid),  64'(0));
    tick();
    check("d_wait1_odd",  64'(odd_valid), 64'(0));
    check("d_wait1_stall", 64'(stall_cnt), 64'(1));
    tick();
    check("d_wait2_odd",  64'(odd_valid), 64'(0));
    check("d_wait2_stall", 64'(stall_cnt), 64'(2));
    tick();
    check("d1_odd_valid", 64'(odd_valid), 64'(1));
    check("d1_odd_instr", 64'(odd_instr), 64'h0D1);
    check("d_stall_cnt",  64'(stall_cnt), 64'(2));

    // Cross-pair WAW on r9 with lat=7
    in_valid = 1'b1;
    set_slot(0, 1'b1, 32'hE0, 1'b0, 1'b1, 7'd9, 7'd0, 3'b000, 3'd7);
    tick();
    set_slot(0, 1'b1, 32'hF0, 1'b1, 1'b1, 7'd9, 7'd0, 3'b000, 3'd1);
    set_slot(1, 1'b1, 32'hF1, 1'b0, 1'b0, 7'd0, 7'd0, 3'b000, 3'd1);
    #1 check("f_in_ready", 64'(in_ready), 64'(1));
    tick();
    idle();
    check("e0_even_valid", 64'(even_valid), 64'(1));
    check("e0_even_instr", 64'(even_instr), 64'h0E0);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("f_wait_even", 64'(even_valid), 64'(0));
      check("f_wait_odd",  64'(odd_valid),  64'(0));
    end
    tick();
    check("f0_odd_valid",  64'(odd_valid),  64'(1));
    check("f0_odd_instr",  64'(odd_instr),  64'h0F0);
    check("f1_even_valid", 64'(even_valid), 64'(1));
    check("f1_even_instr", 64'(even_instr), 64'h0F1);
    check("f_dual_cnt",    64'(dual_cnt),   64'(3));
    check("f_stall_cnt",   64'(stall_cnt),  64'(9));

    // Flush while G1 waits on r5 (lat=3)
    in_valid = 1'b1;
    set_slot(0, 1'b1, 32'h60, 1'b0, 1'b1, 7'd5, 7'd0, 3'b000, 3'd3);
    set_slot(1, 1'b1, 32'h61, 1'b1, 1'b0, 7'd0, 7'd5, 3'b111, 3'd1);
    tick();
    idle();
    tick();
    check("g0_even_instr", 64'(even_instr), 64'h060);
    flush = 1'b1;
    #1 check("flush_in_ready", 64'(in_ready), 64'(0));
    tick();
    flush = 1'b0;
    check("flush_even_valid", 64'(even_valid), 64'(0));
    check("flush_odd_valid",  64'(odd_valid),  64'(0));
    check("flush_stall_cnt",  64'(stall_cnt),  64'(9));
    #1 check("flush_in_ready_after", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    set_slot(0, 1'b1, 32'h70, 1'b1, 1'b0, 7'd0, 7'd5, 3'b111, 3'd1);
    tick();
    idle();
    check("g1_dropped_odd", 64'(odd_valid), 64'(0));
    tick();
    check("h_wait_odd",   64'(odd_valid), 64'(0));
    check("h_wait_stall", 64'(stall_cnt), 64'(10));
    tick();
    check("h_odd_valid", 64'(odd_valid), 64'(1));
    check("h_odd_instr", 64'(odd_instr), 64'h070);
    check("h_stall_cnt", 64'(stall_cnt), 64'(10));
    check("sat_stall_cnt", 64'(sat_stall_cnt), 64'(7));
    check("sat_dual_cnt",  64'(sat_dual_cnt),  64'(3));

    // Async reset between edges with pair I held
    in_valid = 1'b1;
    set_slot(0, 1'b1, 32'h80, 1'b0, 1'b1, 7'd7, 7'd0, 3'b000, 3'd5);
    set_slot(1, 1'b1, 32'h81, 1'b1, 1'b1, 7'd8, 7'd0, 3'b000, 3'd5);
    tick();
    idle();
    reset = 1'b1;
    #1;
    check("arst_even_instr", 64'(even_instr), 64'(0));
    check("arst_odd_instr",  64'(odd_instr),  64'(0));
    check("arst_dual_cnt",   64'(dual_cnt),   64'(0));
    check("arst_stall_cnt",  64'(stall_cnt),  64'(0));
    check("arst_even_valid", 64'(even_valid), 64'(0));
    tick();
    reset = 1'b0;
    #1 check("arst_in_ready", 64'(in_ready), 64'(1));
    tick();
    check("i_dropped_even", 64'(even_valid), 64'(0));
    check("i_dropped_odd",  64'(odd_valid),  64'(0));
    check("sat_in_ready",   64'(sat_in_ready), 64'(1));
    in_valid = 1'b1;
    set_slot(0, 1'b1, 32'h90, 1'b0, 1'b1, 7'd7, 7'd0, 3'b000, 3'd2);
    set_slot(1, 1'b1, 32'h91, 1'b1, 1'b1, 7'd9, 7'd8, 3'b111, 3'd2);
    tick();
    idle();
    check("j_lat_even", 64'(even_valid), 64'(0));
    tick();
    check("j_even_valid", 64'(even_valid), 64'(1));
    check("j_even_instr", 64'(even_instr), 64'h090);
    check("j_odd_valid",  64'(odd_valid),  64'(1));
    check("j_odd_instr",  64'(odd_instr),  64'h091);
    check("j_dual_cnt",   64'(dual_cnt),   64'(1));
    check("j_stall_cnt",  64'(stall_cnt),  64'(0));
    check("sat_j_even_valid", 64'(sat_even_valid), 64'(1));
    check("sat_j_odd_valid",  64'(sat_odd_valid),  64'(1));
    check("sat_j_even_instr", 64'(sat_even_instr), 64'h090);
    check("sat_j_odd_instr",  64'(sat_odd_instr),  64'h091);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
